// File: rtl/fifo_axis_drain.sv
// fifo_axis_drain: pops a FIFO into a registered AXI-stream master with programmable TLAST framing
module fifo_axis_drain #(
    parameter int BW    = 8,
    parameter int LGPKT = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_fifo_empty,
    input  logic [BW-1:0]    i_fifo_data,
    output logic             o_fifo_rd,
    input  logic [LGPKT-1:0] i_pkt_len,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [BW-1:0]    o_m_data,
    output logic             o_m_last,
    output logic             o_pkt_done
);
    logic             skid_valid;
    logic [BW-1:0]    skid_data;
    logic             skid_last;
    logic [LGPKT-1:0] cnt;
    logic [LGPKT-1:0] len_r;
    logic             last_w;

    // Popping depends only on registered state, never on i_m_ready
    assign o_fifo_rd = !i_fifo_empty && !skid_valid && !i_reset;

    // TLAST tag for the word being popped; the first beat uses the live length
    always_comb
        last_w = (cnt == '0) ? (i_pkt_len == '0) : (cnt == len_r);

    // Beat counter and packet length latched at each packet's first beat
    always_ff @(posedge i_clk)
        if (i_reset) begin
            cnt   <= '0;
            len_r <= '0;
        end else if (o_fifo_rd) begin
            cnt <= last_w ? '0 : cnt + 1'b1;
            if (cnt == '0)
                len_r <= i_pkt_len;
        end

    // Output register plus skid: skid absorbs the word popped during a stall
    always_ff @(posedge i_clk)
        if (i_reset) begin
            o_m_valid  <= 1'b0;
            o_m_data   <= '0;
            o_m_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (!o_m_valid || i_m_ready) begin
            o_m_valid  <= skid_valid || o_fifo_rd;
            skid_valid <= 1'b0;
            if (skid_valid) begin
                o_m_data <= skid_data;
                o_m_last <= skid_last;
            end else if (o_fifo_rd) begin
                o_m_data <= i_fifo_data;
                o_m_last <= last_w;
            end
        end else if (o_fifo_rd) begin
            skid_valid <= 1'b1;
            skid_data  <= i_fifo_data;
            skid_last  <= last_w;
        end

    // Pulse the cycle after a TLAST beat handshakes
    always_ff @(posedge i_clk)
        if (i_reset)
            o_pkt_done <= 1'b0;
        else
            o_pkt_done <= o_m_valid && i_m_ready && o_m_last;

`ifdef FORMAL
    logic f_past_valid = 1'b0;

    // Gate $past-based checks until one clock has elapsed
    always @(posedge i_clk)
        f_past_valid <= 1'b1;

    // AXI-stream stability, skid occupancy and no-loss properties
    always @(posedge i_clk)
        if (f_past_valid && !$past(i_reset)) begin
            if ($past(o_m_valid && !i_m_ready)) begin
                assert (o_m_valid);
                assert ($stable(o_m_data));
                assert ($stable(o_m_last));
            end
            if ($past(o_m_valid && !i_m_ready && o_fifo_rd))
                assert (skid_valid && skid_data == $past(i_fifo_data));
            if (skid_valid)
                assert (o_m_valid);
            if ($past(skid_valid && i_m_ready))
                assert (o_m_data == $past(skid_data) && !skid_valid);
        end
`endif
endmodule

// File: tb/tb_fifo_axis_drain.sv
// tb_fifo_axis_drain: directed vector table plus hand sequences for the AXI-stream FIFO drain
module tb_fifo_axis_drain;
    typedef struct {
        logic       rdy;
        logic [7:0] len;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       done;
        logic       rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_en = 1'b0;
    logic [7:0] mem [64];
    int         wptr = 0;
    int         rptr = 0;
    logic       fifo_empty, fifo_rd;
    logic [7:0] fifo_data;
    logic [7:0] pkt_len = 8'd3;
    logic       m_ready = 1'b1;
    logic       m_valid, m_last, pkt_done;
    logic [7:0] m_data;

    logic [7:0] mem2 [16];
    int         wptr2 = 0;
    int         rptr2 = 0;
    logic       fifo_empty2, fifo_rd2;
    logic [7:0] fifo_data2;
    logic [1:0] pkt_len2 = 2'd3;
    logic       m_ready2 = 1'b1;
    logic       m_valid2, m_last2, pkt_done2;
    logic [7:0] m_data2;

    vec_t vecs [35];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    assign fifo_empty  = (rptr == wptr);
    assign fifo_data   = mem[rptr[5:0]];
    assign fifo_empty2 = (rptr2 == wptr2);
    assign fifo_data2  = mem2[rptr2[3:0]];

    // FIFO models: reset flushes the queue when enabled, read strobe advances the head
    always @(posedge clk) begin
        if (rst && clr_en)
            rptr <= wptr;
        else if (fifo_rd)
            rptr <= rptr + 1;
        if (rst)
            rptr2 <= wptr2;
        else if (fifo_rd2)
            rptr2 <= rptr2 + 1;
    end

    fifo_axis_drain #(.BW(8), .LGPKT(8)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
        .o_fifo_rd(fifo_rd), .i_pkt_len(pkt_len), .o_m_valid(m_valid), .i_m_ready(m_ready),
        .o_m_data(m_data), .o_m_last(m_last), .o_pkt_done(pkt_done)
    );

    fifo_axis_drain #(.BW(8), .LGPKT(2)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_fifo_empty(fifo_empty2), .i_fifo_data(fifo_data2),
        .o_fifo_rd(fifo_rd2), .i_pkt_len(pkt_len2), .o_m_valid(m_valid2), .i_m_ready(m_ready2),
        .o_m_data(m_data2), .o_m_last(m_last2), .o_pkt_done(pkt_done2)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr[5:0]] = base + 8'(i);
            wptr++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int i);
        m_ready = vecs[i].rdy;
        pkt_len = vecs[i].len;
        tick();
        chk($sformatf("v%0d_valid", i), {7'd0, m_valid}, {7'd0, vecs[i].v});
        chk($sformatf("v%0d_data", i), m_data, vecs[i].d);
        chk($sformatf("v%0d_last", i), {7'd0, m_last}, {7'd0, vecs[i].l});
        chk($sformatf("v%0d_done", i), {7'd0, pkt_done}, {7'd0, vecs[i].done});
        chk($sformatf("v%0d_rd", i), {7'd0, fifo_rd}, {7'd0, vecs[i].rd});
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, {7'd0, m_valid}, 8'd0);
        chk({name, "_data"}, m_data, 8'd0);
        chk({name, "_last"}, {7'd0, m_last}, 8'd0);
        chk({name, "_done"}, {7'd0, pkt_done}, 8'd0);
        chk({name, "_rd"}, {7'd0, fifo_rd}, 8'd0);
    endtask

    initial begin
        // Streaming, len 3: TLAST on 0x13 and 0x17
        vecs[0]  = '{1, 3, 1, 8'h10, 0, 0, 1};
        vecs[1]  = '{1, 3, 1, 8'h11, 0, 0, 1};
        vecs[2]  = '{1, 3, 1, 8'h12, 0, 0, 1};
        vecs[3]  = '{1, 3, 1, 8'h13, 1, 0, 1};
        vecs[4]  = '{1, 3, 1, 8'h14, 0, 1, 1};
        vecs[5]  = '{1, 3, 1, 8'h15, 0, 0, 1};
        vecs[6]  = '{1, 3, 1, 8'h16, 0, 0, 1};
        vecs[7]  = '{1, 3, 1, 8'h17, 1, 0, 0};
        vecs[8]  = '{1, 3, 0, 8'h17, 1, 1, 0};
        vecs[9]  = '{1, 3, 0, 8'h17, 1, 0, 0};
        // Backpressure: ready low 5 cycles, one word into skid
        vecs[10] = '{1, 3, 1, 8'h20, 0, 0, 1};
        vecs[11] = '{0, 3, 1, 8'h20, 0, 0, 0};
        vecs[12] = '{0, 3, 1, 8'h20, 0, 0, 0};
        vecs[13] = '{0, 3, 1, 8'h20, 0, 0, 0};
        vecs[14] = '{0, 3, 1, 8'h20, 0, 0, 0};
        vecs[15] = '{0, 3, 1, 8'h20, 0, 0, 0};
        vecs[16] = '{1, 3, 1, 8'h21, 0, 0, 1};
        vecs[17] = '{1, 3, 1, 8'h22, 0, 0, 1};
        vecs[18] = '{1, 3, 1, 8'h23, 1, 0, 1};
        vecs[19] = '{1, 3, 1, 8'h24, 0, 1, 1};
        vecs[20] = '{1, 3, 1, 8'h25, 0, 0, 1};
        vecs[21] = '{1, 3, 1, 8'h26, 0, 0, 1};
        vecs[22] = '{1, 3, 1, 8'h27, 1, 0, 0};
        vecs[23] = '{1, 3, 0, 8'h27, 1, 1, 0};
        vecs[24] = '{1, 3, 0, 8'h27, 1, 0, 0};
        // Length changed 3 -> 0 during beat 2
        vecs[25] = '{1, 3, 1, 8'h30, 0, 0, 1};
        vecs[26] = '{1, 0, 1, 8'h31, 0, 0, 1};
        vecs[27] = '{1, 0, 1, 8'h32, 0, 0, 1};
        vecs[28] = '{1, 0, 1, 8'h33, 1, 0, 1};
        vecs[29] = '{1, 0, 1, 8'h34, 1, 1, 1};
        vecs[30] = '{1, 0, 1, 8'h35, 1, 1, 1};
        vecs[31] = '{1, 0, 1, 8'h36, 1, 1, 1};
        vecs[32] = '{1, 0, 1, 8'h37, 1, 1, 0};
        vecs[33] = '{1, 0, 0, 8'h37, 1, 1, 0};
        vecs[34] = '{1, 0, 0, 8'h37, 1, 0, 0};

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem2[i] = 8'h00;

        load(8'h10, 8);
        #1;
        chk("rst_rd_async", {7'd0, fifo_rd}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("rst%0d", i));
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) apply(i);
        load(8'h20, 8);
        for (int i = 10; i < 25; i++) apply(i);
        load(8'h30, 8);
        for (int i = 25; i < 35; i++) apply(i);

        // Reset during a stalled packet: cnt at 3, skid full
        load(8'h50, 4);
        m_ready = 1'b1;
        pkt_len = 8'd3;
        tick();
        chk("mr_d1", m_data, 8'h50);
        tick();
        chk("mr_d2", m_data, 8'h51);
        m_ready = 1'b0;
        tick();
        chk("mr_stall_data", m_data, 8'h51);
        chk("mr_stall_rd", {7'd0, fifo_rd}, 8'd0);
        tick();
        chk("mr_stall_valid", {7'd0, m_valid}, 8'd1);
        rst = 1'b1;
        clr_en = 1'b1;
        tick();
        chk_idle("mr_rst0");
        tick();
        chk_idle("mr_rst1");
        rst = 1'b0;
        clr_en = 1'b0;
        m_ready = 1'b1;
        pkt_len = 8'd1;
        load(8'h60, 2);
        tick();
        chk("mr_b1_valid", {7'd0, m_valid}, 8'd1);
        chk("mr_b1_data", m_data, 8'h60);
        chk("mr_b1_last", {7'd0, m_last}, 8'd0);
        tick();
        chk("mr_b2_data", m_data, 8'h61);
        chk("mr_b2_last", {7'd0, m_last}, 8'd1);
        tick();
        chk("mr_end_valid", {7'd0, m_valid}, 8'd0);
        chk("mr_end_done", {7'd0, pkt_done}, 8'd1);

        // Maximum length on the LGPKT=2 instance: 4-beat packets, 9 words
        for (int i = 0; i < 9; i++) mem2[i] = 8'h40 + 8'(i);
        wptr2 = 9;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("max%0d_valid", k), {7'd0, m_valid2}, 8'd1);
            chk($sformatf("max%0d_data", k), m_data2, 8'h40 + 8'(k - 1));
            chk($sformatf("max%0d_last", k), {7'd0, m_last2}, {7'd0, k % 4 == 0});
            chk($sformatf("max%0d_done", k), {7'd0, pkt_done2}, {7'd0, k == 5 || k == 9});
        end
        tick();
        chk("max_end_valid", {7'd0, m_valid2}, 8'd0);
        chk("max_end_done", {7'd0, pkt_done2}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
